wb_cmd_initiator: RTL and testbench

WB_CMD_INITIATOR -- requirements
Module: wb_cmd_initiator

---
 rtl/wb_cmd_initiator_if.sv | 23 ++
 rtl/wb_cmd_initiator.sv | 144 ++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_initiator_if.sv
// Wishbone initiator/responder signal bundle used by wb_cmd_initiator.
//   master : drives cyc/stb/we/adr/dat/sel, receives ack and read data
//   slave  : the responder side of the same wires
interface wb_cmd_initiator_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_cmd_initiator.sv
// Single-outstanding Wishbone initiator: turns one command into one bus
// transfer and returns one response (read data, or an error on timeout).
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_we/adr/dat/sel payload
//   rsp_valid/rsp_ready      response handshake; rsp_dat, rsp_err payload
//   busy                     high whenever the block is not idle
//   wb                       Wishbone initiator side (master modport)
module wb_cmd_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  wb_cmd_initiator_if.master wb
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // Last BUS cycle index before giving up on the responder.
  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  count_q, count_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          count_d = '0;
        end
      end

      S_BUS: begin
        // Ack wins over timeout when both land in the same cycle.
        if (wb.wb_ack_i) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wb.wb_dat_i;
        end else if (count_q == LAST_CYCLE) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 32'hFFFF_FFFF;
        end else begin
          count_d = count_q + 8'd1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  // cyc and stb always move together, so one register drives both.
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_dat   = rsp_dat_q;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed testbench for wb_cmd_initiator (TIMEOUT = 16).
module tb_wb_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  wb_cmd_initiator_if wb_bus ();

  wb_cmd_initiator #(.TIMEOUT(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .wb        (wb_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    wb_bus.wb_ack_i = 1'b0;
    wb_bus.wb_dat_i = '0;

    // ---------------- reset state ----------------
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cyc", wb_bus.wb_cyc_o, 0);
    check("rst_stb", wb_bus.wb_stb_o, 0);
    check("rst_we", wb_bus.wb_we_o, 0);
    check("rst_adr", wb_bus.wb_adr_o, 0);
    check("rst_dat", wb_bus.wb_dat_o, 0);
    check("rst_sel", wb_bus.wb_sel_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    rst = 1'b0;
    tick();

    // ---------------- write, ack in C1 ----------------
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h2400_0004;
    cmd_dat   = 32'h1234_5678;
    cmd_sel   = 4'hF;
    tick();  // C0 edge -> now in C1; cmd_valid stays high but must be ignored
    check("wr_c1_cyc", wb_bus.wb_cyc_o, 1);
    check("wr_c1_stb", wb_bus.wb_stb_o, 1);
    check("wr_c1_we", wb_bus.wb_we_o, 1);
    check("wr_c1_adr", wb_bus.wb_adr_o, 32'h2400_0004);
    check("wr_c1_dat", wb_bus.wb_dat_o, 32'h1234_5678);
    check("wr_c1_sel", wb_bus.wb_sel_o, 4'hF);
    check("wr_c1_cmd_ready", cmd_ready, 0);
    check("wr_c1_busy", busy, 1);
    check("wr_c1_rsp_valid", rsp_valid, 0);
    wb_bus.wb_ack_i = 1'b1;
    wb_bus.wb_dat_i = 32'h5555_AAAA;  // must not appear as write response
    tick();  // C2
    cmd_valid = 1'b0;
    wb_bus.wb_ack_i = 1'b0;
    check("wr_c2_cyc", wb_bus.wb_cyc_o, 0);
    check("wr_c2_stb", wb_bus.wb_stb_o, 0);
    check("wr_c2_rsp_valid", rsp_valid, 1);
    check("wr_c2_rsp_err", rsp_err, 0);
    check("wr_c2_rsp_dat", rsp_dat, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_done_rsp_valid", rsp_valid, 0);
    check("wr_done_cmd_ready", cmd_ready, 1);
    tick();
    // The command seen while busy was not queued.
    check("wr_no_queue_cyc", wb_bus.wb_cyc_o, 0);
    check("wr_no_queue_busy", busy, 0);

    // ---------------- read, ack after 3 wait cycles ----------------
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h2400_0008;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h3;
    tick();  // now C1
    cmd_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("rd_wait%0d_cyc", i), wb_bus.wb_cyc_o, 1);
      tick();
    end
    check("rd_c4_cyc", wb_bus.wb_cyc_o, 1);
    check("rd_c4_adr", wb_bus.wb_adr_o, 32'h2400_0008);
    check("rd_c4_we", wb_bus.wb_we_o, 0);
    wb_bus.wb_ack_i = 1'b1;
    wb_bus.wb_dat_i = 32'h0000_00A5;
    tick();
    wb_bus.wb_ack_i = 1'b0;
    check("rd_rsp_cyc", wb_bus.wb_cyc_o, 0);
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_rsp_dat", rsp_dat, 32'h0000_00A5);

    // ---------------- backpressure with a pending command ----------------
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h2400_000C;
    cmd_sel   = 4'hF;
    wb_bus.wb_dat_i = 32'hDEAD_BEEF;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("bp%0d_rsp_dat", i), rsp_dat, 32'h0000_00A5);
      check($sformatf("bp%0d_cmd_ready", i), cmd_ready, 0);
      check($sformatf("bp%0d_cyc", i), wb_bus.wb_cyc_o, 0);
    end
    rsp_ready = 1'b1;
    tick();  // response consumed; command must not be taken on this edge
    rsp_ready = 1'b0;
    check("bp_release_rsp_valid", rsp_valid, 0);
    check("bp_release_cyc", wb_bus.wb_cyc_o, 0);
    check("bp_release_cmd_ready", cmd_ready, 1);
    tick();  // accepted one cycle later
    cmd_valid = 1'b0;
    check("bp_next_cyc", wb_bus.wb_cyc_o, 1);
    check("bp_next_adr", wb_bus.wb_adr_o, 32'h2400_000C);

    // ---------------- timeout, no ack ----------------
    n = 0;
    while (wb_bus.wb_cyc_o === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("to_cyc_cycles", n, 16);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_dat", rsp_dat, 32'hFFFF_FFFF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("to_done_rsp_valid", rsp_valid, 0);

    // ---------------- ack in the 16th cycle wins ----------------
    cmd_valid = 1'b1;
    cmd_adr   = 32'h2400_0010;
    tick();  // C1
    cmd_valid = 1'b0;
    for (int i = 1; i <= 15; i++) tick();  // now C16
    check("to_ack_c16_cyc", wb_bus.wb_cyc_o, 1);
    wb_bus.wb_ack_i = 1'b1;
    wb_bus.wb_dat_i = 32'hCAFE_0001;
    tick();
    wb_bus.wb_ack_i = 1'b0;
    check("to_ack_cyc", wb_bus.wb_cyc_o, 0);
    check("to_ack_rsp_valid", rsp_valid, 1);
    check("to_ack_rsp_err", rsp_err, 0);
    check("to_ack_rsp_dat", rsp_dat, 32'hCAFE_0001);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---------------- reset in the 2nd BUS cycle ----------------
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h2400_0014;
    cmd_dat   = 32'h0BAD_F00D;
    tick();  // C1
    cmd_valid = 1'b0;
    tick();  // C2
    check("rs_c2_cyc", wb_bus.wb_cyc_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_cyc", wb_bus.wb_cyc_o, 0);
    check("rs_stb", wb_bus.wb_stb_o, 0);
    check("rs_rsp_valid", rsp_valid, 0);
    check("rs_cmd_ready", cmd_ready, 1);
    check("rs_adr", wb_bus.wb_adr_o, 0);
    tick();
    check("rs_after_rsp_valid", rsp_valid, 0);

    // Ack held in IDLE must be ignored.
    wb_bus.wb_ack_i = 1'b1;
    wb_bus.wb_dat_i = 32'h0;
    tick();
    check("idle_ack_cyc", wb_bus.wb_cyc_o, 0);
    check("idle_ack_rsp_valid", rsp_valid, 0);

    // Fresh write completes normally (ack already high in C1).
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h2400_0018;
    cmd_dat   = 32'h7777_1111;
    cmd_sel   = 4'h5;
    tick();  // C1
    cmd_valid = 1'b0;
    check("fr_c1_cyc", wb_bus.wb_cyc_o, 1);
    check("fr_c1_dat", wb_bus.wb_dat_o, 32'h7777_1111);
    check("fr_c1_sel", wb_bus.wb_sel_o, 4'h5);
    tick();  // C2
    wb_bus.wb_ack_i = 1'b0;
    check("fr_c2_cyc", wb_bus.wb_cyc_o, 0);
    check("fr_c2_rsp_valid", rsp_valid, 1);
    check("fr_c2_rsp_err", rsp_err, 0);
    check("fr_c2_rsp_dat", rsp_dat, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("fr_done_rsp_valid", rsp_valid, 0);
    check("fr_done_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
